// File: rtl/dmem_port_arbiter.sv
// Shares the single DataMemory port between the core load/store path and a debug/loader master.
// Core accesses complete in the granted cycle; debug gets registered read data and a bounded lock.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              MemRead,
    output logic              MemWrite
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CORE,
        ST_DBG,
        ST_DBG_LOCK
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_gnt_dbg;
    logic [HOLD_W-1:0] hold_cnt;
    logic              core_gnt;

    // Grant arbitration: single requester, then bounded lock, then round robin
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!reset) begin
            if (core_req && !dbg_req) begin
                core_gnt = 1'b1;
            end else if (dbg_req && !core_req) begin
                dbg_gnt = 1'b1;
            end else if (core_req && dbg_req) begin
                if (state == ST_DBG_LOCK && dbg_lock && hold_cnt < HOLD_MAX) begin
                    dbg_gnt = 1'b1;
                end else if (last_gnt_dbg) begin
                    core_gnt = 1'b1;
                end else begin
                    dbg_gnt = 1'b1;
                end
            end
        end
    end

    // Memory port mux; idle port drives zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            MemRead   = ~core_we;
            MemWrite  = core_we;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            MemRead   = ~dbg_we;
            MemWrite  = dbg_we;
        end
    end

    assign core_rdata = mem_rdata;
    assign core_stall = core_req & ~core_gnt & ~reset;

    always_comb begin
        state_nxt = ST_IDLE;
        if (core_gnt) begin
            state_nxt = ST_CORE;
        end else if (dbg_gnt) begin
            state_nxt = dbg_lock ? ST_DBG_LOCK : ST_DBG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_gnt_dbg <= 1'b1;
            hold_cnt     <= '0;
            dbg_rdata    <= '0;
            dbg_rvalid   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (core_gnt) begin
                last_gnt_dbg <= 1'b0;
            end else if (dbg_gnt) begin
                last_gnt_dbg <= 1'b1;
            end
            // Starvation counter only runs while the core is actually waiting
            if (core_gnt || !core_req) begin
                hold_cnt <= '0;
            end else if (dbg_gnt && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural DataMemory model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [6:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_stall;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [6:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        MemRead, MemWrite;

    logic [31:0] mem [128];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (MemWrite) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [6:0] a, input logic [31:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic lk, input logic [6:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        mem[5] = 32'h0000_0055;
        reset = 1'b1;
        drive_core(1'b1, 1'b0, 7'd5, 32'h0);
        drive_dbg(1'b1, 1'b0, 1'b0, 7'd3, 32'h0);
        cyc();
        mid();
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_rdata", dbg_rdata, 32'h0);
        cyc();
        reset = 1'b0;

        // Core load alone
        drive_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        mid();
        check("t1_memread", 32'(MemRead), 32'd1);
        check("t1_memwrite", 32'(MemWrite), 32'd0);
        check("t1_addr", 32'(mem_addr), 32'd5);
        check("t1_stall", 32'(core_stall), 32'd0);
        check("t1_rdata", core_rdata, 32'h55);
        cyc();

        // Debug write then read
        drive_core(1'b0, 1'b0, 7'd0, 32'h0);
        drive_dbg(1'b1, 1'b1, 1'b0, 7'd3, 32'hDEAD_BEEF);
        mid();
        check("t2_wr_gnt", 32'(dbg_gnt), 32'd1);
        check("t2_memwrite", 32'(MemWrite), 32'd1);
        check("t2_wr_addr", 32'(mem_addr), 32'd3);
        check("t2_wr_data", mem_wdata, 32'hDEAD_BEEF);
        cyc();
        drive_dbg(1'b1, 1'b0, 1'b0, 7'd3, 32'h0);
        check("t2_no_rvalid_wr", 32'(dbg_rvalid), 32'd0);
        mid();
        check("t2_memread", 32'(MemRead), 32'd1);
        check("t2_rd_gnt", 32'(dbg_gnt), 32'd1);
        cyc();
        drive_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        check("t2_rvalid", 32'(dbg_rvalid), 32'd1);
        check("t2_rdata", dbg_rdata, 32'hDEAD_BEEF);
        mid();
        check("t2_idle_memread", 32'(MemRead), 32'd0);
        check("t2_idle_addr", 32'(mem_addr), 32'd0);
        cyc();
        check("t2_rvalid_drop", 32'(dbg_rvalid), 32'd0);
        check("t2_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);

        // Round robin from reset: core, dbg, core, dbg
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_core(1'b1, 1'b0, 7'd10, 32'h0);
            drive_dbg(1'b1, 1'b0, 1'b0, 7'd20, 32'h0);
            mid();
            check($sformatf("t3_dbg_gnt%0d", i), 32'(dbg_gnt), 32'(i % 2));
            check($sformatf("t3_stall%0d", i), 32'(core_stall), 32'(i % 2));
            check($sformatf("t3_addr%0d", i), 32'(mem_addr), (i % 2 == 1) ? 32'd20 : 32'd10);
            cyc();
        end

        // Locked burst bounded by MAX_HOLD=8, then round robin once the lock drops
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic exp_dbg;
            exp_dbg = ((i >= 1) && (i <= 8)) || (i == 10);
            drive_core(1'b1, 1'b0, 7'd10, 32'h0);
            drive_dbg(1'b1, 1'b0, (i <= 9), 7'd20, 32'h0);
            mid();
            check($sformatf("t4_dbg_gnt%0d", i), 32'(dbg_gnt), 32'(exp_dbg));
            check($sformatf("t4_stall%0d", i), 32'(core_stall), 32'(exp_dbg));
            cyc();
        end

        // Reset during a locked debug read burst
        drive_core(1'b0, 1'b0, 7'd0, 32'h0);
        drive_dbg(1'b1, 1'b0, 1'b1, 7'd3, 32'h0);
        mid();
        check("t5_gnt0", 32'(dbg_gnt), 32'd1);
        cyc();
        mid();
        check("t5_gnt1", 32'(dbg_gnt), 32'd1);
        check("t5_rvalid1", 32'(dbg_rvalid), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_gnt", 32'(dbg_gnt), 32'd0);
        check("t5_rst_memread", 32'(MemRead), 32'd0);
        check("t5_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        cyc();
        reset = 1'b0;
        drive_core(1'b1, 1'b0, 7'd9, 32'h0);
        mid();
        check("t5_core_first_stall", 32'(core_stall), 32'd0);
        check("t5_core_first_dbg", 32'(dbg_gnt), 32'd0);
        check("t5_core_first_addr", 32'(mem_addr), 32'd9);
        check("t5_rvalid_post", 32'(dbg_rvalid), 32'd0);
        cyc();

        // Core store at the top address, then the tie goes to debug
        drive_core(1'b1, 1'b1, 7'h7F, 32'h1234_5678);
        drive_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        mid();
        check("t6_memwrite", 32'(MemWrite), 32'd1);
        check("t6_addr", 32'(mem_addr), 32'h7F);
        check("t6_wdata", mem_wdata, 32'h1234_5678);
        cyc();
        drive_core(1'b1, 1'b0, 7'd1, 32'h0);
        drive_dbg(1'b1, 1'b0, 1'b0, 7'd2, 32'h0);
        mid();
        check("t6_tie_dbg", 32'(dbg_gnt), 32'd1);
        check("t6_tie_stall", 32'(core_stall), 32'd1);
        check("t6_tie_addr", 32'(mem_addr), 32'd2);
        cyc();
        drive_core(1'b1, 1'b0, 7'h7F, 32'h0);
        drive_dbg(1'b0, 1'b0, 1'b0, 7'd0, 32'h0);
        mid();
        check("t6_readback", core_rdata, 32'h1234_5678);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
